// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizing for the SDRAM command arbiter.
// Holds the FSM state enum and the default address/data/refresh parameters.
package sdram_arb_pkg;

  localparam int ADDR_W_DEF           = 26;
  localparam int DATA_W_DEF           = 8;
  localparam int REFRESH_INTERVAL_DEF = 512;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD,
    ST_WAIT
  } state_e;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh timer with pending flag and sticky overrun.
// Ports: clk, resetn, clr_i (refresh strobed), pending_o, overrun_o.
module sdram_refresh_timer
  import sdram_arb_pkg::*;
#(
  parameter int INTERVAL = REFRESH_INTERVAL_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr_i,
  output logic pending_o,
  output logic overrun_o
);

  localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          ovr_q, ovr_d;
  logic          wrap;

  always_comb begin
    wrap  = (cnt_q == LAST);
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    pend_d = pend_q;
    if (clr_i) pend_d = 1'b0;
    // A new wrap outranks a same-cycle clear: that refresh is a fresh one.
    if (wrap)  pend_d = 1'b1;
    ovr_d = ovr_q | (wrap & pend_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign pending_o = pend_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Two-requester SDRAM command arbiter with refresh priority.
// Ports: req_* (requesters), rsp_* (read return), mem_* (controller).
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W           = ADDR_W_DEF,
  parameter int DATA_W           = DATA_W_DEF,
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ack,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_valid,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                mem_refresh,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  input  logic [DATA_W-1:0]   mem_dout,
  input  logic                mem_busy,
  input  logic                mem_data_ready,
  output logic                refresh_overrun
);

  state_e              state_q, state_d;
  logic                owner_q, last_q, is_ref_q, we_q, seen_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q, rdata_q;
  logic [1:0]          rvalid_q;
  logic                ref_pend, grant, start, is_read, cap, done, issue;

  sdram_refresh_timer #(
    .INTERVAL (REFRESH_INTERVAL)
  ) u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .clr_i     (mem_refresh),
    .pending_o (ref_pend),
    .overrun_o (refresh_overrun)
  );

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (req_valid == 2'b11): grant = ~last_q;
      (req_valid == 2'b10): grant = 1'b1;
      default:              grant = 1'b0;
    endcase
  end

  always_comb begin
    start   = (ref_pend | (|req_valid)) & ~mem_busy;
    is_read = ~is_ref_q & ~we_q;
    cap     = is_read & mem_data_ready & ~seen_q &
              ((state_q == ST_HOLD) | (state_q == ST_WAIT));
    // Data may arrive in the same cycle busy drops.
    done    = ~mem_busy & (~is_read | seen_q | mem_data_ready);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_HOLD;
      ST_HOLD:  state_d = ST_WAIT;
      ST_WAIT:  if (done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      is_ref_q <= 1'b0;
      we_q     <= 1'b0;
      seen_q   <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 2'b00;
    end else begin
      rvalid_q <= 2'b00;
      if (state_q == ST_IDLE && start) begin
        is_ref_q <= ref_pend;
        seen_q   <= 1'b0;
        if (!ref_pend) begin
          owner_q <= grant;
          last_q  <= grant;
          we_q    <= req_we[grant];
          addr_q  <= grant ? req_addr[2*ADDR_W-1:ADDR_W]
                           : req_addr[ADDR_W-1:0];
          din_q   <= grant ? req_wdata[2*DATA_W-1:DATA_W]
                           : req_wdata[DATA_W-1:0];
        end
      end
      if (cap) begin
        seen_q   <= 1'b1;
        rdata_q  <= mem_dout;
        rvalid_q <= owner_q ? 2'b10 : 2'b01;
      end
    end
  end

  always_comb begin
    issue       = (state_q == ST_ISSUE);
    mem_refresh = issue & is_ref_q;
    mem_wr      = issue & ~is_ref_q & we_q;
    mem_rd      = issue & ~is_ref_q & ~we_q;
    req_ack     = 2'b00;
    if (issue && !is_ref_q) req_ack = owner_q ? 2'b10 : 2'b01;
  end

  assign mem_addr  = addr_q;
  assign mem_din   = din_q;
  assign rsp_rdata = rdata_q;
  assign rsp_valid = rvalid_q;

endmodule
